// File: rtl/ifmap_frame_loader.sv
// Ping-pong frame collector and kernel loader feeding the convolution stage.
// Presents one complete IFMAP frame plus a stable filter under a frame handshake.
module ifmap_frame_loader #(
    parameter int unsigned IP_DATA_WIDTH = 8,
    parameter int unsigned IFMAP_SIZE    = 8,
    parameter int unsigned FILTER_SIZE   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IP_DATA_WIDTH-1:0] in_data,
    input  logic                     in_last,
    input  logic                     flt_valid,
    input  logic [IP_DATA_WIDTH-1:0] flt_data,
    output logic [IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][IP_DATA_WIDTH-1:0]   ifmap,
    output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] filter,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     frame_err,
    output logic                     filter_loaded
);

    localparam int unsigned NumCoef = FILTER_SIZE * FILTER_SIZE;
    localparam int unsigned IdxW    = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
    localparam int unsigned CoefW   = (NumCoef > 1) ? $clog2(NumCoef) : 1;
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(IFMAP_SIZE - 1);
    localparam logic [CoefW-1:0] LastCoef = CoefW'(NumCoef - 1);

    typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_st_e;
    typedef logic [IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][IP_DATA_WIDTH-1:0] frame_t;
    typedef logic [NumCoef-1:0][IP_DATA_WIDTH-1:0] kernel_t;

    bank_st_e         bank_st_q [2];
    bank_st_e         bank_st_d [2];
    frame_t           bank_q [2];
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IdxW-1:0]  row_q, row_d;
    logic [IdxW-1:0]  col_q, col_d;
    logic             frame_err_q, frame_err_d;
    kernel_t          shadow_q, shadow_d;
    kernel_t          pend_q, pend_d;
    kernel_t          filter_q, filter_d;
    logic [CoefW-1:0] coef_q, coef_d;
    logic             pend_vld_q, pend_vld_d;
    logic             loaded_q, loaded_d;

    logic accept, final_pix, handshake, copy, last_coef;

    assign accept    = in_valid && in_ready;
    assign final_pix = (row_q == LastIdx) && (col_q == LastIdx);
    assign handshake = frame_valid && frame_ready;
    assign copy      = pend_vld_q && (!frame_valid || handshake);
    assign last_coef = flt_valid && (coef_q == LastCoef);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_st_q[0] <= StEmpty;
            bank_st_q[1] <= StEmpty;
            bank_q[0]    <= '0;
            bank_q[1]    <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            frame_err_q  <= 1'b0;
            shadow_q     <= '0;
            pend_q       <= '0;
            filter_q     <= '0;
            coef_q       <= '0;
            pend_vld_q   <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            bank_st_q   <= bank_st_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            frame_err_q <= frame_err_d;
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            filter_q    <= filter_d;
            coef_q      <= coef_d;
            pend_vld_q  <= pend_vld_d;
            loaded_q    <= loaded_d;
            if (accept) begin
                bank_q[wr_bank_q][row_q][col_q] <= in_data;
            end
        end
    end

    always_comb begin
        bank_st_d   = bank_st_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        row_d       = row_q;
        col_d       = col_q;
        frame_err_d = 1'b0;
        shadow_d    = shadow_q;
        pend_d      = pend_q;
        filter_d    = filter_q;
        coef_d      = coef_q;
        pend_vld_d  = pend_vld_q;
        loaded_d    = loaded_q;

        if (accept) begin
            if (final_pix) begin
                // Commit even without in_last; the missing marker is only flagged.
                bank_st_d[wr_bank_q] = StFull;
                wr_bank_d            = ~wr_bank_q;
                row_d                = '0;
                col_d                = '0;
                frame_err_d          = !in_last;
            end else if (in_last) begin
                bank_st_d[wr_bank_q] = StEmpty;
                row_d                = '0;
                col_d                = '0;
                frame_err_d          = 1'b1;
            end else begin
                bank_st_d[wr_bank_q] = StFilling;
                if (col_q == LastIdx) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end

        // Only a FULL bank can be released, so it never collides with the write bank update.
        if (handshake) begin
            bank_st_d[rd_bank_q] = StEmpty;
            rd_bank_d            = ~rd_bank_q;
        end

        if (copy) begin
            filter_d   = pend_q;
            loaded_d   = 1'b1;
            pend_vld_d = 1'b0;
        end

        if (flt_valid) begin
            shadow_d[coef_q] = flt_data;
            if (last_coef) begin
                coef_d     = '0;
                pend_d     = shadow_d;
                pend_vld_d = 1'b1;
            end else begin
                coef_d = coef_q + 1'b1;
            end
        end
    end

    always_comb begin
        in_ready      = (bank_st_q[wr_bank_q] != StFull);
        frame_valid   = (bank_st_q[rd_bank_q] == StFull) && loaded_q;
        ifmap         = bank_q[rd_bank_q];
        filter        = filter_q;
        frame_err     = frame_err_q;
        filter_loaded = loaded_q;
    end

endmodule
